// File: rtl/fix_sub.sv
`default_nettype none
// ============================================================================
// fix_sub : two-stage valid/ready signed fixed-point subtractor (a - b)
//           with overflow flag, optional saturation and sticky overflow.
// Revision: 1.0
// ============================================================================
module fix_sub #(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_q, b_q;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH:0]   d_ext;
  logic             d_ovf;
  logic [WIDTH-1:0] d_res;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;

    // One guard bit makes the true difference representable.
    d_ext  = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    d_ovf  = d_ext[WIDTH] ^ d_ext[WIDTH-1];
    d_res  = d_ext[WIDTH-1:0];
    if (d_ovf && SAT) begin
      d_res = d_ext[WIDTH] ? C_MIN : C_MAX;
    end

    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

    diff_d = diff_q;
    ovf_d  = ovf_q;
    if (s2_adv && s1_valid_q) begin
      diff_d = d_res;
      ovf_d  = d_ovf;
    end

    // A set in the same cycle as a clear takes priority.
    if (s2_valid_q && out_ready && ovf_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign diff       = diff_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fix_sub.sv
`default_nettype none
// tb_fix_sub : scoreboard bench driving a saturating and a wrapping fix_sub
// with identical stimulus and checking both against an arithmetic model.
module tb_fix_sub;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_ready = 1'b0;
  logic         clr_sticky = 1'b0;

  logic         in_ready_s, out_valid_s, ovf_s, sticky_s;
  logic [W-1:0] diff_s;
  logic         in_ready_w, out_valid_w, ovf_w, sticky_w;
  logic [W-1:0] diff_w;

  fix_sub #(.WIDTH(W), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .diff(diff_s), .ovf(ovf_s), .ovf_sticky(sticky_s), .clr_sticky(clr_sticky));

  fix_sub #(.WIDTH(W), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .diff(diff_w), .ovf(ovf_w), .ovf_sticky(sticky_w), .clr_sticky(clr_sticky));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ds;
    logic [W-1:0] dw;
    logic         o;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   lat_mode = 1'b0;
  bit   rnd_rdy = 1'b0;
  logic exp_st_s = 1'b0, exp_st_w = 1'b0;
  bit   held_v = 1'b0;
  logic [W-1:0] held_ds, held_dw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: exact integer difference, then range test.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sat);
    longint d;
    logic   o;
    logic [W-1:0] r;
    d = longint'($signed(x)) - longint'($signed(y));
    o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    r = d[W-1:0];
    if (o && sat) r = (d > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {o, r};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic xfer, eo;
    cyc++;
    if (!rst_n) begin
      held_v   = 1'b0;
      exp_st_s = 1'b0;
      exp_st_w = 1'b0;
    end else if (mon_en) begin
      chk("in_ready_sat", {63'd0, in_ready_s}, {63'd0, (sb.size() < 2) || out_ready});
      chk("in_ready_wrap", {63'd0, in_ready_w}, {63'd0, (sb.size() < 2) || out_ready});
      chk("out_valid_match", {63'd0, out_valid_w}, {63'd0, out_valid_s});
      chk("sticky_sat", {63'd0, sticky_s}, {63'd0, exp_st_s});
      chk("sticky_wrap", {63'd0, sticky_w}, {63'd0, exp_st_w});
      if (held_v) begin
        chk("hold_valid", {63'd0, out_valid_s}, 64'd1);
        chk("hold_diff_sat", {32'd0, diff_s}, {32'd0, held_ds});
        chk("hold_diff_wrap", {32'd0, diff_w}, {32'd0, held_dw});
      end
      xfer = out_valid_s && out_ready;
      eo   = 1'b0;
      if (out_valid_s && sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else if (xfer) begin
        e  = sb.pop_front();
        eo = e.o;
        chk("diff_sat", {32'd0, diff_s}, {32'd0, e.ds});
        chk("diff_wrap", {32'd0, diff_w}, {32'd0, e.dw});
        chk("ovf_sat", {63'd0, ovf_s}, {63'd0, e.o});
        chk("ovf_wrap", {63'd0, ovf_w}, {63'd0, e.o});
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
      end
      exp_st_s = (xfer && eo) ? 1'b1 : (clr_sticky ? 1'b0 : exp_st_s);
      exp_st_w = (xfer && eo) ? 1'b1 : (clr_sticky ? 1'b0 : exp_st_w);
      held_v  = out_valid_s && !out_ready;
      held_ds = diff_s;
      held_dw = diff_w;
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [W:0] ms, mw;
    bit done = 1'b0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      #1;
      if (in_ready_s) begin
        ms = model(av, bv, 1'b1);
        mw = model(av, bv, 1'b0);
        e.ds = ms[W-1:0];
        e.dw = mw[W-1:0];
        e.o = ms[W];
        e.cyc = cyc;
        e.lat = lat_mode;
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] edge_vals [4];
    edge_vals[0] = 32'h7FFF_FFFF;
    edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h0000_0001;

    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", {63'd0, out_valid_s}, 64'd0);
    chk("rst_diff", {32'd0, diff_s}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_s}, 64'd0);
    chk("rst_sticky", {63'd0, sticky_s}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_s}, 64'd1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic, back-to-back with latency checked
    out_ready = 1'b1;
    lat_mode = 1'b1;
    send(32'd5, 32'd3);
    send(-32'sd7, 32'd10);
    drain();
    lat_mode = 1'b0;

    // Saturation / wrap corners
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    send(32'h8000_0000, 32'd1);
    send(32'h8000_0000, 32'h8000_0000);
    drain();
    repeat (2) tick();

    // Sticky clear, then clear coincident with an overflow transfer
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    repeat (2) tick();
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    repeat (2) tick();

    // Fill both stages under stall, then release
    out_ready = 1'b0;
    send(32'd100, 32'd1);
    send(32'd200, 32'd2);
    repeat (3) tick();
    out_ready = 1'b1;
    drain();

    // Backpressured stream a=i, b=2i
    rnd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(W'(i), W'(2 * i));
    // Random operands with gaps and corner values
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 2) == 0)
        send(edge_vals[$urandom_range(0, 3)], edge_vals[$urandom_range(0, 3)]);
      else
        send($urandom, $urandom);
    end
    rnd_rdy = 1'b0;
    #2 out_ready = 1'b1;
    drain();

    // Asynchronous reset with two transactions in flight
    send(32'h8000_0000, 32'd1);
    drain();
    out_ready = 1'b0;
    send(32'd1, 32'd2);
    send(32'd3, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid_s}, 64'd0);
    chk("mid_rst_diff", {32'd0, diff_s}, 64'd0);
    chk("mid_rst_ovf", {63'd0, ovf_s}, 64'd0);
    chk("mid_rst_sticky", {63'd0, sticky_s}, 64'd0);
    chk("mid_rst_sticky_wrap", {63'd0, sticky_w}, 64'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready_s}, 64'd1);
    out_ready = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
